// File: rtl/rca_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
package rca_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca4.sv
// 4-bit ripple-carry adder, the single arithmetic datapath of the controller.
module rca4
    import rca_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] carry_s;

    // Bit-by-bit full-adder ripple chain
    always_comb begin
        carry_s    = '0;
        sum        = '0;
        carry_s[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
        end
    end

    assign cout = carry_s[NIB_W];

endmodule

// File: rtl/rca4_seq_adder.sv
// WIDTH-bit add/subtract built by feeding one rca4 a nibble per clock, LSB first,
// with the carry held in a register between passes.
module rca4_seq_adder
    import rca_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic [NIB_W-1:0]   nib_a_s;
    logic [NIB_W-1:0]   nib_b_s;
    logic [NIB_W-1:0]   nib_sum_s;
    logic               nib_cout_s;
    logic               last_s;

    assign nib_a_s = a_r[int'(idx_r)*NIB_W +: NIB_W];
    assign nib_b_s = b_r[int'(idx_r)*NIB_W +: NIB_W];
    assign last_s  = (idx_r == IDX_W'(NIB - 1));

    rca4 u_rca4 (
        .a    (nib_a_s),
        .b    (nib_b_s),
        .cin  (carry_r),
        .sum  (nib_sum_s),
        .cout (nib_cout_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Operand capture, per-nibble pass and result latching
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        // Subtraction is A + ~B + 1, so B is stored inverted.
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        idx_r   <= '0;
                        sum_r   <= '0;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                RUN: begin
                    sum_r[int'(idx_r)*NIB_W +: NIB_W] <= nib_sum_s;
                    carry_r <= nib_cout_s;
                    if (last_s) begin
                        cout_r <= nib_cout_s;
                        ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &
                                  (nib_sum_s[NIB_W-1] != a_r[WIDTH-1]);
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    idx_r <= idx_r;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_rca4_seq_adder.sv
// Randomized and directed checks of rca4_seq_adder against an integer-arithmetic model.
module tb_rca4_seq_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, sub, cout, ovf;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, sum4;
    logic        cin4, sub4, cout4, ovf4;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rca4_seq_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    rca4_seq_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    // Reference: {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [17:0] model16(input logic [15:0] ma, input logic [15:0] mb,
                                            input logic mcin, input logic msub);
        int ua, ub, sa, sb, ures, sres;
        logic [15:0] r;
        logic c, o;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            ures = ua - ub;
            sres = sa - sb;
            c    = (ua >= ub);
        end else begin
            ures = ua + ub + int'(mcin);
            sres = sa + sb + int'(mcin);
            c    = (ures > 65535);
        end
        r = ures[15:0];
        o = (sres > 32767) || (sres < -32768);
        return {o, c, r};
    endfunction

    // Drive one op from IDLE, wait for result, take it; reports cycles from accept to out_valid
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                         input logic tsub, output logic [15:0] rs, output logic rc,
                         output logic ro, output int lat, output logic leak);
        in_valid = 1'b1; a = ta; b = tb_v; cin = tcin; sub = tsub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat  = 0;
        leak = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) leak = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) leak = 1'b1;
        rs = sum; rc = cout; ro = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; sub4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset: rdy=%b vld=%b sum=%h c=%b o=%b, expected 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        tests_run++;
        if ({in_ready4, out_valid4} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_w4: rdy=%b vld=%b, expected 1 0", in_ready4, out_valid4);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] vb [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] ve [5] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                                {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};
        logic [15:0] rs;
        logic rc, ro, leak;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run16(va[i], vb[i], 1'b0, vs[i], rs, rc, ro, lat, leak);
            tests_run++;
            if ({ro, rc, rs} !== ve[i]) begin
                tests_failed++;
                $display("FAIL directed[%0d]: got {ovf,cout,sum}=%h, expected %h", i, {ro, rc, rs}, ve[i]);
            end
            tests_run++;
            if (lat !== 4 || leak !== 1'b0) begin
                tests_failed++;
                $display("FAIL directed_timing[%0d]: lat=%0d in_ready_while_busy=%b, expected 4 0",
                         i, lat, leak);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ra, rb, rs;
        logic rci, rsb, rc, ro, leak;
        logic [17:0] exp;
        int lat;
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rci = 1'($urandom); rsb = 1'($urandom);
            if (i % 5 == 0) rb = ra;
            exp = model16(ra, rb, rci, rsb);
            run16(ra, rb, rci, rsb, rs, rc, ro, lat, leak);
            tests_run++;
            if ({ro, rc, rs} !== exp || lat !== 4) begin
                tests_failed++;
                $display("FAIL random[%0d] a=%h b=%h cin=%b sub=%b: got %h lat=%0d, expected %h lat=4",
                         i, ra, rb, rci, rsb, {ro, rc, rs}, lat, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] rs;
        logic rc, ro, leak;
        int lat;
        int guard;
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 16'h3333, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL backpressure[%0d]: vld=%b rdy=%b sum=%h c=%b o=%b, expected 1 0 3333 0 0",
                         i, out_valid, in_ready, sum, cout, ovf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL release: rdy=%b vld=%b, expected 1 0", in_ready, out_valid);
        end
        run16(16'hAAAA, 16'h5555, 1'b0, 1'b0, rs, rc, ro, lat, leak);
        tests_run++;
        if ({ro, rc, rs} !== {2'b00, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL after_backpressure: got %h, expected 0ffff", {ro, rc, rs});
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] rs;
        logic rc, ro, leak;
        int lat;
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h1111; cin = 1'b1; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset_mid_run: rdy=%b vld=%b sum=%h, expected 1 0 0000",
                     in_ready, out_valid, sum);
        end
        run16(16'h00FF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat, leak);
        tests_run++;
        if ({ro, rc, rs} !== {2'b00, 16'h0100} || lat !== 4) begin
            tests_failed++;
            $display("FAIL post_reset_op: got %h lat=%0d, expected 00100 lat=4", {ro, rc, rs}, lat);
        end
    endtask

    task automatic test_width4();
        in_valid4 = 1'b1; a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; sub4 = 1'b0;
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        @(posedge clk); #1;
        tests_run++;
        if ({out_valid4, ovf4, cout4, sum4} !== {1'b1, 1'b1, 1'b1, 4'h1}) begin
            tests_failed++;
            $display("FAIL width4: vld=%b o=%b c=%b sum=%h, expected 1 1 1 1",
                     out_valid4, ovf4, cout4, sum4);
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        tests_run++;
        if ({in_ready4, out_valid4} !== 2'b10) begin
            tests_failed++;
            $display("FAIL width4_release: rdy=%b vld=%b, expected 1 0", in_ready4, out_valid4);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_width4();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rca4_seq_adder.md
Name: rca4_seq_adder

Overview:
- Multi-cycle controller that time-multiplexes one rca4 4-bit ripple-carry adder to add or subtract WIDTH-bit operands, one nibble per clock, LSB nibble first.
- Registered carry chains the passes.
- Valid/ready handshake on both input and result sides.
- Sits between an operand source (CPU/test harness) and any consumer that needs wide sums while keeping a single 4-bit adder instance.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived localparam: number of nibble passes.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  controller can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  1 = A - B, 0 = A + B + cin
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result
- cout  output  1  final carry-out; in sub mode, 1 = no borrow (A >= B unsigned)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, nibble index=0, carry reg=0, operand regs=0.
  - sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready=1 once in IDLE.
  - rst has priority over every other event, in every state.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On in_valid & in_ready, capture a into a_reg.
  - Capture b into b_reg, inverted if sub=1.
  - carry reg = sub ? 1 : cin.
  - idx=0, sum reg cleared. Go to RUN.
- RUN, each edge:
  - Drive rca4 with a_reg[4*idx+:4], b_reg[4*idx+:4] and the carry reg.
  - Write the rca4 sum into sum[4*idx+:4]; carry reg <= rca4 cout.
  - If idx==NIB-1: latch cout; compute ovf = (a_reg MSB == b_reg MSB) & (sum MSB != a_reg MSB), using the new sum MSB; go to DONE. Otherwise idx++.
- DONE:
  - Hold sum/cout/ovf stable until out_valid & out_ready, then go to IDLE.
  - out_ready while not in DONE has no effect.
- Latency and throughput:
  - Accept edge, then NIB RUN edges; out_valid=1 in the cycle after the NIB-th RUN edge.
  - WIDTH=16: out_valid is high 4 cycles after the accept cycle.
  - Minimum issue interval: NIB+2 cycles, since in_ready=0 in RUN and DONE and there is no overlap.
- Inputs:
  - in_valid while busy is ignored; operands are not queued.
  - a/b/cin/sub may change after the accept edge without affecting the result.
- Widths and boundaries:
  - All arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.
  - WIDTH=4 (NIB=1): RUN lasts exactly one edge.
  - idx never exceeds NIB-1.
- Reset mid-RUN or mid-DONE: the operation is discarded, the result is lost and out_valid drops in the next cycle.

Decomposition:
- Shared package rca_ctrl_pkg holds:
  - State encodings as localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Nibble width constant NIB_W=4.
- Exactly one sub-module: the existing rca4 instance, used as the sole adder datapath.
- FSM, index counter, carry reg and operand/sum regs live in rca4_seq_adder.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, sub=0 -> after 4 RUN cycles out_valid=1, sum=0x5555, cout=0, ovf=0; in_ready=0 from accept until the result is taken.
- a=0xFFFF, b=0x0001 add -> sum=0x0000, cout=1, ovf=0 (carry propagates across all 4 passes); a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
- sub: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: out_ready=0 for 10 cycles in DONE with in_valid=1 and new operands -> sum/cout/ovf stable, in_ready=0, nothing accepted; out_ready=1 -> IDLE next cycle, then the new op is accepted.
- rst=1 during RUN (idx=2) -> next cycle IDLE, out_valid=0, sum=0; a following op 0x00FF+0x0001 returns 0x0100 with no stale carry.
- WIDTH=4 build: a=0x9, b=0x8, add -> out_valid 1 cycle after accept, sum=0x1, cout=1, ovf=1.
